// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin imem/dmem arbiter with 3-slave decode and watchdog
module bus_arbiter #(
  parameter logic [31:0] START_ADDR = 32'h0,
  parameter int          BRAM_DEPTH = 12,
  parameter logic [31:0] UART_ADDR  = 32'h100000,
  parameter logic [31:0] TIMER_ADDR = 32'h200000,
  parameter int          TIMEOUT    = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        imem_valid,
  input  logic [31:0] imem_addr,
  output logic        imem_ready,
  output logic [31:0] imem_rdata,
  output logic        imem_error,
  input  logic        dmem_valid,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic        dmem_ready,
  output logic [31:0] dmem_rdata,
  output logic        dmem_error,
  output logic [2:0]  slv_valid,
  output logic        slv_instr,
  output logic [31:0] slv_addr,
  output logic [31:0] slv_wdata,
  output logic [3:0]  slv_wstrb,
  input  logic [2:0]  slv_ready,
  input  logic [95:0] slv_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

  localparam logic [32:0] BRAM_SPAN = 33'd4 << BRAM_DEPTH;
  localparam logic [15:0] WD_LAST   = 16'(TIMEOUT - 1);

  state_t      state;
  logic        gnt_dmem;
  logic        last_dmem;
  logic [15:0] wd;

  logic        pick_dmem;
  logic [31:0] req_addr;
  logic [31:0] bram_off;
  logic [2:0]  hit;
  logic [31:0] req_off;
  logic        sel_ready;
  logic [31:0] sel_rdata;
  logic        tmo;
  logic        done;
  logic        err;
  logic [31:0] rdata;

  // Ties go to whichever requester did not win last time; last_dmem=0 after reset.
  always_comb begin
    pick_dmem = dmem_valid && (!imem_valid || !last_dmem);
    req_addr  = pick_dmem ? dmem_addr : imem_addr;
    bram_off  = req_addr - START_ADDR;
    hit       = 3'b000;
    req_off   = req_addr;
    if ({1'b0, bram_off} < BRAM_SPAN) begin
      hit     = 3'b001;
      req_off = bram_off;
    end else if (req_addr[31:2] == UART_ADDR[31:2]) begin
      hit     = 3'b010;
      req_off = req_addr - UART_ADDR;
    end else if (req_addr[31:4] == TIMER_ADDR[31:4]) begin
      hit     = 3'b100;
      req_off = req_addr - TIMER_ADDR;
    end
  end

  // slv_valid doubles as the one-hot target select while BUSY.
  always_comb begin
    sel_ready = |(slv_ready & slv_valid);
    sel_rdata = 32'h0;
    case (slv_valid)
      3'b001:  sel_rdata = slv_rdata[31:0];
      3'b010:  sel_rdata = slv_rdata[63:32];
      3'b100:  sel_rdata = slv_rdata[95:64];
      default: sel_rdata = 32'h0;
    endcase
    tmo   = (state == BUSY) && (TIMEOUT != 0) && !sel_ready && (wd == WD_LAST);
    done  = ((state == BUSY) && (sel_ready || tmo)) || (state == ERR);
    err   = (state == ERR) || tmo;
    rdata = ((state == BUSY) && sel_ready) ? sel_rdata : 32'h0;
    imem_ready = done && !gnt_dmem;
    imem_error = err && !gnt_dmem;
    imem_rdata = gnt_dmem ? 32'h0 : rdata;
    dmem_ready = done && gnt_dmem;
    dmem_error = err && gnt_dmem;
    dmem_rdata = gnt_dmem ? rdata : 32'h0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      gnt_dmem  <= 1'b0;
      last_dmem <= 1'b0;
      wd        <= 16'h0;
      slv_valid <= 3'b000;
      slv_instr <= 1'b0;
      slv_addr  <= 32'h0;
      slv_wdata <= 32'h0;
      slv_wstrb <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (imem_valid || dmem_valid) begin
            gnt_dmem  <= pick_dmem;
            last_dmem <= pick_dmem;
            wd        <= 16'h0;
            slv_instr <= !pick_dmem;
            slv_addr  <= req_off;
            slv_wdata <= dmem_wdata;
            slv_wstrb <= pick_dmem ? dmem_wstrb : 4'h0;
            if (hit != 3'b000) begin
              slv_valid <= hit;
              state     <= BUSY;
            end else begin
              state <= ERR;
            end
          end
        end
        BUSY: begin
          if (sel_ready || tmo) begin
            slv_valid <= 3'b000;
            state     <= IDLE;
          end else begin
            wd <= wd + 16'd1;
          end
        end
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter
module tb_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_valid;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        imem_error;
  logic        dmem_valid;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        dmem_error;
  logic [2:0]  slv_valid;
  logic        slv_instr;
  logic [31:0] slv_addr;
  logic [31:0] slv_wdata;
  logic [3:0]  slv_wstrb;
  logic [2:0]  slv_ready;
  logic [95:0] slv_rdata;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clock = ~clock;

  bus_arbiter #(.TIMEOUT(8)) dut (
    .clock(clock), .reset(reset),
    .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .imem_error(imem_error),
    .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .dmem_error(dmem_error),
    .slv_valid(slv_valid), .slv_instr(slv_instr), .slv_addr(slv_addr),
    .slv_wdata(slv_wdata), .slv_wstrb(slv_wstrb), .slv_ready(slv_ready),
    .slv_rdata(slv_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic next_cycle;
    @(posedge clock);
    #1;
  endtask

  task automatic settle;
    @(negedge clock);
  endtask

  task automatic idle_inputs;
    imem_valid = 1'b0; imem_addr = 32'h0;
    dmem_valid = 1'b0; dmem_addr = 32'h0; dmem_wdata = 32'h0; dmem_wstrb = 4'h0;
    slv_ready = 3'b000; slv_rdata = 96'h0;
  endtask

  task automatic reset_dut;
    idle_inputs();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  // Requesters must hold valid until ready.
  logic d_pend = 1'b0;
  logic i_pend = 1'b0;
  always @(negedge clock) begin
    if (!reset) begin
      if (d_pend) check("hold_dmem_valid", {31'h0, dmem_valid}, 32'd1);
      if (i_pend) check("hold_imem_valid", {31'h0, imem_valid}, 32'd1);
    end
    d_pend <= !reset && dmem_valid && !dmem_ready;
    i_pend <= !reset && imem_valid && !imem_ready;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    @(posedge clock); #1;
    reset_dut();

    settle();
    check("rst_slv_valid", {29'h0, slv_valid}, 32'h0);
    check("rst_ready", {30'h0, imem_ready, dmem_ready}, 32'h0);
    check("rst_error", {30'h0, imem_error, dmem_error}, 32'h0);
    check("rst_rdata", imem_rdata | dmem_rdata, 32'h0);

    // BRAM write, slave ready one cycle after slv_valid
    next_cycle();
    dmem_valid = 1'b1; dmem_addr = 32'h10; dmem_wdata = 32'hDEADBEEF; dmem_wstrb = 4'hF;
    next_cycle();
    settle();
    check("wr_slv_valid", {29'h0, slv_valid}, 32'b001);
    check("wr_slv_addr", slv_addr, 32'h10);
    check("wr_slv_wdata", slv_wdata, 32'hDEADBEEF);
    check("wr_slv_wstrb", {28'h0, slv_wstrb}, 32'hF);
    check("wr_slv_instr", {31'h0, slv_instr}, 32'h0);
    check("wr_early_ready", {31'h0, dmem_ready}, 32'h0);
    next_cycle();
    slv_ready = 3'b001;
    settle();
    check("wr_dmem_ready", {31'h0, dmem_ready}, 32'd1);
    check("wr_dmem_error", {31'h0, dmem_error}, 32'h0);
    check("wr_imem_ready", {31'h0, imem_ready}, 32'h0);
    next_cycle();
    idle_inputs();
    settle();
    check("wr_drop_valid", {29'h0, slv_valid}, 32'h0);
    check("wr_ready_pulse", {31'h0, dmem_ready}, 32'h0);

    // Tie after reset: dmem (UART) first, then repeated tie goes to imem (BRAM)
    reset_dut();
    imem_valid = 1'b1; imem_addr = 32'h0;
    dmem_valid = 1'b1; dmem_addr = 32'h100000; dmem_wdata = 32'h55; dmem_wstrb = 4'h3;
    next_cycle();
    slv_ready = 3'b010; slv_rdata = {32'h0, 32'hA5A50001, 32'h0};
    settle();
    check("tie1_slv_valid", {29'h0, slv_valid}, 32'b010);
    check("tie1_slv_instr", {31'h0, slv_instr}, 32'h0);
    check("tie1_slv_wstrb", {28'h0, slv_wstrb}, 32'h3);
    check("tie1_slv_addr", slv_addr, 32'h0);
    check("tie1_dmem_ready", {31'h0, dmem_ready}, 32'd1);
    check("tie1_dmem_rdata", dmem_rdata, 32'hA5A50001);
    check("tie1_imem_ready", {31'h0, imem_ready}, 32'h0);
    next_cycle();
    slv_ready = 3'b000;
    settle();
    check("tie_idle_gap", {29'h0, slv_valid}, 32'h0);
    next_cycle();
    slv_ready = 3'b001; slv_rdata = {64'h0, 32'h00000013};
    settle();
    check("tie2_slv_valid", {29'h0, slv_valid}, 32'b001);
    check("tie2_slv_instr", {31'h0, slv_instr}, 32'd1);
    check("tie2_slv_wstrb", {28'h0, slv_wstrb}, 32'h0);
    check("tie2_imem_ready", {31'h0, imem_ready}, 32'd1);
    check("tie2_imem_rdata", imem_rdata, 32'h13);
    check("tie2_dmem_ready", {31'h0, dmem_ready}, 32'h0);
    next_cycle();
    imem_valid = 1'b0; slv_ready = 3'b000;
    next_cycle();
    slv_ready = 3'b010;
    settle();
    check("tie3_slv_valid", {29'h0, slv_valid}, 32'b010);
    check("tie3_dmem_ready", {31'h0, dmem_ready}, 32'd1);
    next_cycle();
    idle_inputs();

    // Unmapped address
    next_cycle();
    dmem_valid = 1'b1; dmem_addr = 32'h300000;
    next_cycle();
    slv_ready = 3'b111; slv_rdata = {96{1'b1}};
    settle();
    check("unm_dmem_ready", {31'h0, dmem_ready}, 32'd1);
    check("unm_dmem_error", {31'h0, dmem_error}, 32'd1);
    check("unm_dmem_rdata", dmem_rdata, 32'h0);
    check("unm_slv_valid", {29'h0, slv_valid}, 32'h0);
    next_cycle();
    idle_inputs();
    settle();
    check("unm_ready_pulse", {31'h0, dmem_ready}, 32'h0);

    // Timer read; unselected slave readies ignored first
    next_cycle();
    dmem_valid = 1'b1; dmem_addr = 32'h20000C;
    next_cycle();
    slv_ready = 3'b011; slv_rdata = {32'h12345678, 32'h11111111, 32'h22222222};
    settle();
    check("tmr_slv_valid", {29'h0, slv_valid}, 32'b100);
    check("tmr_slv_addr", slv_addr, 32'hC);
    check("tmr_unsel_ready", {31'h0, dmem_ready}, 32'h0);
    next_cycle();
    slv_ready = 3'b100;
    settle();
    check("tmr_dmem_ready", {31'h0, dmem_ready}, 32'd1);
    check("tmr_dmem_rdata", dmem_rdata, 32'h12345678);
    check("tmr_dmem_error", {31'h0, dmem_error}, 32'h0);
    next_cycle();
    idle_inputs();

    // Watchdog: BRAM never ready, TIMEOUT=8
    next_cycle();
    dmem_valid = 1'b1; dmem_addr = 32'h40; slv_rdata = {3{32'hFEEDFACE}};
    for (int i = 1; i <= 7; i++) begin
      next_cycle();
      settle();
      check($sformatf("wd_wait%0d_ready", i), {31'h0, dmem_ready}, 32'h0);
      check($sformatf("wd_wait%0d_valid", i), {29'h0, slv_valid}, 32'b001);
    end
    next_cycle();
    settle();
    check("wd_dmem_ready", {31'h0, dmem_ready}, 32'd1);
    check("wd_dmem_error", {31'h0, dmem_error}, 32'd1);
    check("wd_dmem_rdata", dmem_rdata, 32'h0);
    next_cycle();
    dmem_valid = 1'b0; slv_ready = 3'b001;
    settle();
    check("wd_slv_valid_drop", {29'h0, slv_valid}, 32'h0);
    check("wd_late_ready", {31'h0, dmem_ready}, 32'h0);
    next_cycle();
    idle_inputs();

    // Reset mid-transaction, then a fresh request
    next_cycle();
    dmem_valid = 1'b1; dmem_addr = 32'h100000;
    next_cycle();
    settle();
    check("rmid_slv_valid", {29'h0, slv_valid}, 32'b010);
    next_cycle();
    reset = 1'b1; dmem_valid = 1'b0;
    next_cycle();
    reset = 1'b0;
    settle();
    check("rmid_after_valid", {29'h0, slv_valid}, 32'h0);
    check("rmid_after_ready", {30'h0, imem_ready, dmem_ready}, 32'h0);
    next_cycle();
    dmem_valid = 1'b1; dmem_addr = 32'h8;
    next_cycle();
    slv_ready = 3'b001; slv_rdata = {64'h0, 32'h0000CAFE};
    settle();
    check("fresh_slv_valid", {29'h0, slv_valid}, 32'b001);
    check("fresh_slv_addr", slv_addr, 32'h8);
    check("fresh_dmem_ready", {31'h0, dmem_ready}, 32'd1);
    check("fresh_dmem_rdata", dmem_rdata, 32'h0000CAFE);
    next_cycle();
    idle_inputs();
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
